// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order queue of fetch-time predictions, retired by
// execute. Each resolve produces a registered training update for the predictor,
// a mispredict/flush pulse on a wrong guess, and accuracy statistics.
module branch_resolve_unit #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_valid,
  output logic                       pred_ready,
  input  logic [31:0]                pred_pc,
  input  logic                       pred_taken,
  input  logic                       pred_is_branch,
  input  logic                       res_valid,
  input  logic                       res_taken,
  input  logic                       res_is_branch,
  output logic                       upd_valid,
  output logic [31:0]                upd_pc,
  output logic                       upd_taken,
  output logic                       upd_is_branch,
  output logic                       mispredict,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       underflow_err,
  output logic [CNT_W-1:0]           total_branches,
  output logic [CNT_W-1:0]           correct_predictions
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic        is_br;
  } entry_t;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t              state_q, state_d;
  entry_t              entry_q [DEPTH];
  entry_t              entry_d [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                upd_valid_q, upd_valid_d;
  logic [31:0]         upd_pc_q, upd_pc_d;
  logic                upd_taken_q, upd_taken_d;
  logic                upd_is_branch_q, upd_is_branch_d;
  logic                mispredict_q, mispredict_d;
  logic                underflow_q, underflow_d;
  logic [CNT_W-1:0]    total_q, total_d, correct_q, correct_d;

  logic                full, empty, run, resolve, miss, push;
  entry_t              head;

  // Queue status and handshake decode
  always_comb begin
    full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    empty   = (wr_ptr_q == rd_ptr_q);
    run     = (state_q == RUN);
    head    = entry_q[rd_ptr_q[AW-1:0]];
    resolve = res_valid && !empty && run;
    miss    = resolve && ((head.is_br != res_is_branch) ||
                          (res_is_branch && (head.taken != res_taken)));
    // A push that lands on the same edge as a flush is thrown away with the rest.
    push    = pred_valid && !full && run && !miss;
  end

  // Entry storage write
  always_comb begin
    entry_d = entry_q;
    if (push) entry_d[wr_ptr_q[AW-1:0]] = '{pc: pred_pc, taken: pred_taken, is_br: pred_is_branch};
  end

  // Pointer update; a miss drops every queued entry by catching rd up to wr
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = miss ? wr_ptr_q : rd_ptr_q + PW'(resolve);
  end

  // FSM next state: a miss forces exactly one FLUSH cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (miss) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Training update, mispredict pulse, sticky underflow and statistics
  always_comb begin
    upd_valid_d     = 1'b0;
    upd_pc_d        = '0;
    upd_taken_d     = 1'b0;
    upd_is_branch_d = 1'b0;
    mispredict_d    = miss;
    underflow_d     = underflow_q || (res_valid && empty && run);
    total_d         = total_q;
    correct_d       = correct_q;
    if (resolve) begin
      upd_valid_d     = head.is_br || res_is_branch;
      upd_pc_d        = head.pc;
      upd_taken_d     = res_taken;
      upd_is_branch_d = res_is_branch;
      if (res_is_branch) begin
        total_d = total_q + 1'b1;
        if (head.is_br && (head.taken == res_taken)) correct_d = correct_q + 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= RUN;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      upd_valid_q     <= 1'b0;
      upd_pc_q        <= '0;
      upd_taken_q     <= 1'b0;
      upd_is_branch_q <= 1'b0;
      mispredict_q    <= 1'b0;
      underflow_q     <= 1'b0;
      total_q         <= '0;
      correct_q       <= '0;
    end else begin
      state_q         <= state_d;
      entry_q         <= entry_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      upd_valid_q     <= upd_valid_d;
      upd_pc_q        <= upd_pc_d;
      upd_taken_q     <= upd_taken_d;
      upd_is_branch_q <= upd_is_branch_d;
      mispredict_q    <= mispredict_d;
      underflow_q     <= underflow_d;
      total_q         <= total_d;
      correct_q       <= correct_d;
    end
  end

  assign pred_ready          = !full && run;
  assign occupancy           = wr_ptr_q - rd_ptr_q;
  assign upd_valid           = upd_valid_q;
  assign upd_pc              = upd_pc_q;
  assign upd_taken           = upd_taken_q;
  assign upd_is_branch       = upd_is_branch_q;
  assign mispredict          = mispredict_q;
  assign underflow_err       = underflow_q;
  assign total_branches      = total_q;
  assign correct_predictions = correct_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed + random bench for branch_resolve_unit with a reference queue model
// and a scoreboard of expected training/mispredict results.
module tb_branch_resolve_unit;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              pred_valid, pred_ready, pred_taken, pred_is_branch;
  logic [31:0]       pred_pc;
  logic              res_valid, res_taken, res_is_branch;
  logic              upd_valid, upd_taken, upd_is_branch, mispredict, underflow_err;
  logic [31:0]       upd_pc;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CNT_W-1:0]  total_branches, correct_predictions;

  branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .pred_is_branch(pred_is_branch),
    .res_valid(res_valid), .res_taken(res_taken), .res_is_branch(res_is_branch),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_is_branch(upd_is_branch), .mispredict(mispredict), .occupancy(occupancy),
    .underflow_err(underflow_err), .total_branches(total_branches),
    .correct_predictions(correct_predictions)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          taken;
    bit          is_br;
  } ent_t;

  typedef struct {
    bit          res;
    bit          uv;
    logic [31:0] pc;
    bit          ut;
    bit          ub;
    bit          mp;
  } sb_t;

  ent_t        mq[$];
  sb_t         sbq[$];
  bit          m_flush, m_uf;
  logic [31:0] m_total, m_correct;
  int          total = 0;
  int          bad   = 0;

  // Small bimodal predictor trained from the DUT's update port
  logic [1:0] bht [16];
  initial for (int i = 0; i < 16; i++) bht[i] = 2'b01;
  always @(posedge clk)
    if (upd_valid && upd_is_branch) begin
      if (upd_taken && bht[upd_pc[5:2]] != 2'b11) bht[upd_pc[5:2]] <= bht[upd_pc[5:2]] + 2'd1;
      if (!upd_taken && bht[upd_pc[5:2]] != 2'b00) bht[upd_pc[5:2]] <= bht[upd_pc[5:2]] - 2'd1;
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete(); sbq.delete();
    m_flush = 0; m_uf = 0; m_total = '0; m_correct = '0;
  endtask

  // One clock of stimulus: drive at negedge, predict with the model, check after posedge
  task automatic step(input bit pv, input logic [31:0] pc, input bit pt, input bit pb,
                      input bit rv, input bit rt, input bit rb);
    bit m_ready, m_res, m_miss;
    sb_t s;
    ent_t e;
    @(negedge clk);
    pred_valid = pv; pred_pc = pc; pred_taken = pt; pred_is_branch = pb;
    res_valid = rv; res_taken = rt; res_is_branch = rb;
    m_ready = (mq.size() < DEPTH) && !m_flush;
    m_res   = rv && (mq.size() != 0) && !m_flush;
    #1 chk("pred_ready", pred_ready, m_ready);
    if (rv && mq.size() == 0 && !m_flush) m_uf = 1;
    s = '{res: m_res, uv: 0, pc: '0, ut: 0, ub: 0, mp: 0};
    m_miss = 0;
    if (m_res) begin
      e = mq.pop_front();
      m_miss = (e.is_br != rb) || (rb && e.taken != rt);
      s.uv = e.is_br || rb; s.pc = e.pc; s.ut = rt; s.ub = rb; s.mp = m_miss;
      if (rb) begin
        m_total++;
        if (e.is_br && e.taken == rt) m_correct++;
      end
    end
    sbq.push_back(s);
    if (m_flush) m_flush = 0;
    if (m_miss) begin
      mq.delete();
      m_flush = 1;
    end else if (pv && m_ready) begin
      mq.push_back('{pc: pc, taken: pt, is_br: pb});
    end
    @(posedge clk); #1;
    s = sbq.pop_front();
    chk("upd_valid", upd_valid, s.uv);
    chk("mispredict", mispredict, s.mp);
    if (s.res) begin
      chk("upd_pc", upd_pc, s.pc);
      chk("upd_taken", upd_taken, s.ut);
      chk("upd_is_branch", upd_is_branch, s.ub);
    end
    chk("occupancy", occupancy, mq.size());
    chk("underflow_err", underflow_err, m_uf);
    chk("total_branches", total_branches, m_total);
    chk("correct_predictions", correct_predictions, m_correct);
  endtask

  task automatic idle();
    step(0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pred_ready"}, pred_ready, 1);
    chk({tag, "_upd_valid"}, upd_valid, 0);
    chk({tag, "_upd_pc"}, upd_pc, 0);
    chk({tag, "_upd_taken"}, upd_taken, 0);
    chk({tag, "_upd_is_branch"}, upd_is_branch, 0);
    chk({tag, "_mispredict"}, mispredict, 0);
    chk({tag, "_occupancy"}, occupancy, 0);
    chk({tag, "_underflow"}, underflow_err, 0);
    chk({tag, "_total"}, total_branches, 0);
    chk({tag, "_correct"}, correct_predictions, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pred_valid = 0; pred_pc = '0; pred_taken = 0; pred_is_branch = 0;
    res_valid = 0; res_taken = 0; res_is_branch = 0;
    reset = 1;
    model_clear();
    #12;
    check_reset_state("reset");
    @(negedge clk); reset = 0;

    // 1: fill to DEPTH, 9th push refused, then drain with all-correct resolves
    for (int i = 0; i < 9; i++) step(1, 32'h8000_0004 + 32'(4 * i), 1, 1, 0, 0, 0);
    chk("t1_full_occupancy", occupancy, 8);
    chk("t1_full_ready", pred_ready, 0);
    for (int i = 0; i < 8; i++) step(0, '0, 0, 0, 1, 1, 1);
    chk("t1_correct", correct_predictions, 8);
    chk("t1_total", total_branches, 8);

    // 2: taken prediction resolved not-taken -> mispredict, flush cycle
    step(1, 32'h9000_0004, 1, 1, 0, 0, 0);
    step(1, 32'h9000_0008, 1, 1, 0, 0, 0);
    step(0, '0, 0, 0, 1, 0, 1);
    chk("t2_mispredict", mispredict, 1);
    chk("t2_upd_taken", upd_taken, 0);
    chk("t2_upd_pc", upd_pc, 32'h9000_0004);
    chk("t2_occupancy", occupancy, 0);
    step(1, 32'h9000_000c, 0, 1, 1, 0, 1); // FLUSH cycle: push and resolve both ignored
    idle();

    // 3: non-branch resolved as non-branch, then as a branch
    step(1, 32'h9100_0000, 0, 0, 0, 0, 0);
    step(0, '0, 0, 0, 1, 0, 0);
    chk("t3_no_upd", upd_valid, 0);
    step(1, 32'h9100_0004, 0, 0, 0, 0, 0);
    step(0, '0, 0, 0, 1, 1, 1);
    chk("t3_miss", mispredict, 1);
    idle();

    // 4: steady occupancy 3 with push+pop, pointers wrap
    for (int i = 0; i < 3; i++) step(1, 32'hA000_0000 + 32'(4 * i), 0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 32'hA000_0100 + 32'(4 * i), 0, 1, 1, 0, 1);
    chk("t4_occupancy", occupancy, 3);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1, 0, 1);

    // 5: resolve on empty queue
    step(0, '0, 0, 0, 1, 1, 1);
    chk("t5_underflow", underflow_err, 1);
    idle();
    chk("t5_sticky", underflow_err, 1);

    // 6: reset asserted during FLUSH with a mispredict pulse pending
    step(1, 32'hB000_0000, 1, 1, 0, 0, 0);
    step(1, 32'hB000_0004, 1, 1, 0, 0, 0);
    step(1, 32'hB000_0008, 1, 1, 0, 0, 0);
    step(0, '0, 0, 0, 1, 0, 1);
    @(negedge clk);
    reset = 1;
    pred_valid = 0; res_valid = 0;
    #1;
    check_reset_state("t6");
    model_clear();
    @(negedge clk); reset = 0;

    // Random mixed traffic, predictions from the trained table
    for (int n = 0; n < 500; n++) begin
      logic [31:0] pc;
      bit pb, rb, rt;
      pc = 32'hC000_0000 + 32'(4 * $urandom_range(0, 15));
      pb = ($urandom_range(0, 3) != 0);
      rb = ($urandom_range(0, 9) != 0) ? pb : !pb;
      rt = pc[2] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 1), pc, bht[pc[5:2]][1], pb,
           ($urandom_range(0, 2) == 0), rt, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
